// File: rtl/serial_pattern_tx.sv
// serial_pattern_tx: parallel-in, serial-out pattern generator.
//
// A start handshake (start_valid & start_ready) latches a pattern word, an
// active length and a repeat count. The active field pattern[len-1:0] is then
// shifted out MSB first, one bit per transfer (out_valid & out_ready), for
// repeat_cnt+1 passes. done pulses for one cycle after the final transfer.
//
// Optional build macro: SERIAL_PATTERN_TX_GAP_EN
//   defined   - a one-cycle idle gap (out_valid=0) is inserted between passes.
//   undefined - passes are sent back-to-back with no bubble.
//
// Ports:
//   clk          clock, rising-edge active
//   rst          asynchronous reset, active low
//   start_valid  start request
//   start_ready  high only while idle
//   pattern      bits to send (only pattern[len-1:0] used)
//   len          bits per pass, clamped to MAX_LEN
//   repeat_cnt   extra passes
//   out_bit      serial data (registered)
//   out_valid    out_bit meaningful (registered)
//   out_ready    consumer accepts out_bit this cycle
//   busy         high while sending (or in the gap)
//   done         one-cycle pulse after the final bit transfer
module serial_pattern_tx #(
  parameter int unsigned MAX_LEN = 8,
  parameter int unsigned LEN_W   = $clog2(MAX_LEN + 1),
  parameter int unsigned REP_W   = 4
) (
  input  logic               clk,
  input  logic               rst,
  input  logic               start_valid,
  output logic               start_ready,
  input  logic [MAX_LEN-1:0] pattern,
  input  logic [LEN_W-1:0]   len,
  input  logic [REP_W-1:0]   repeat_cnt,
  output logic               out_bit,
  output logic               out_valid,
  input  logic               out_ready,
  output logic               busy,
  output logic               done
);

`ifdef SERIAL_PATTERN_TX_GAP_EN
  typedef enum logic [1:0] {StIdle, StSend, StGap} state_e;
`else
  typedef enum logic [1:0] {StIdle, StSend} state_e;
`endif

  localparam logic [MAX_LEN-1:0] LsbOne = {{(MAX_LEN - 1){1'b0}}, 1'b1};
  localparam logic [LEN_W-1:0]   MaxLen = LEN_W'(MAX_LEN);
  localparam logic [LEN_W-1:0]   LenOne = LEN_W'(1);

  state_e             state_q, state_d;
  logic [MAX_LEN-1:0] pat_q, pat_d;
  logic [LEN_W-1:0]   len_q, len_d;
  logic [LEN_W-1:0]   idx_q, idx_d;
  logic [REP_W-1:0]   rep_q, rep_d;
  logic               out_bit_q, out_bit_d;
  logic               out_valid_q, out_valid_d;
  logic               done_q, done_d;

  logic [LEN_W-1:0]   eff_len;
  logic               start_bit;
  logic               dec_bit;
  logic               top_bit;
  logic               xfer;

  // Lengths beyond the register width are clamped so only real bits are sent.
  assign eff_len = (len > MaxLen) ? MaxLen : len;

  // Bit selection via one-hot masks keeps every pattern bit in use and avoids
  // index-width mismatches between LEN_W and the pattern width.
  assign start_bit = |(pattern & (LsbOne << (eff_len - LenOne)));
  assign dec_bit   = |(pat_q & (LsbOne << (idx_q - LenOne)));
  assign top_bit   = |(pat_q & (LsbOne << (len_q - LenOne)));

  assign xfer = out_valid_q & out_ready;

  always_comb begin
    state_d     = state_q;
    pat_d       = pat_q;
    len_d       = len_q;
    idx_d       = idx_q;
    rep_d       = rep_q;
    out_bit_d   = out_bit_q;
    out_valid_d = out_valid_q;
    done_d      = 1'b0;

    case (state_q)
      StIdle: begin
        if (start_valid) begin
          pat_d = pattern;
          len_d = eff_len;
          rep_d = repeat_cnt;
          if (eff_len == '0) begin
            // Empty pattern: nothing to send, just acknowledge completion.
            done_d = 1'b1;
          end else begin
            state_d     = StSend;
            idx_d       = eff_len - LenOne;
            out_bit_d   = start_bit;
            out_valid_d = 1'b1;
          end
        end
      end

      StSend: begin
        if (xfer) begin
          if (idx_q != '0) begin
            idx_d     = idx_q - LenOne;
            out_bit_d = dec_bit;
          end else if (rep_q != '0) begin
            rep_d = rep_q - REP_W'(1);
            idx_d = len_q - LenOne;
`ifdef SERIAL_PATTERN_TX_GAP_EN
            state_d     = StGap;
            out_valid_d = 1'b0;
            out_bit_d   = 1'b0;
`else
            out_bit_d   = top_bit;
`endif
          end else begin
            state_d     = StIdle;
            out_valid_d = 1'b0;
            out_bit_d   = 1'b0;
            done_d      = 1'b1;
          end
        end
      end

`ifdef SERIAL_PATTERN_TX_GAP_EN
      // Gap lasts exactly one cycle; idx was already reloaded to the MSB.
      StGap: begin
        state_d     = StSend;
        out_valid_d = 1'b1;
        out_bit_d   = top_bit;
      end
`endif

      default: begin
        state_d = StIdle;
      end
    endcase
  end

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      state_q     <= StIdle;
      pat_q       <= '0;
      len_q       <= '0;
      idx_q       <= '0;
      rep_q       <= '0;
      out_bit_q   <= 1'b0;
      out_valid_q <= 1'b0;
      done_q      <= 1'b0;
    end else begin
      state_q     <= state_d;
      pat_q       <= pat_d;
      len_q       <= len_d;
      idx_q       <= idx_d;
      rep_q       <= rep_d;
      out_bit_q   <= out_bit_d;
      out_valid_q <= out_valid_d;
      done_q      <= done_d;
    end
  end

  assign start_ready = (state_q == StIdle);
  assign busy        = (state_q != StIdle);
  assign out_bit     = out_bit_q;
  assign out_valid   = out_valid_q;
  assign done        = done_q;

endmodule

// File: tb/tb_serial_pattern_tx.sv
// Testbench for serial_pattern_tx: randomized and directed streams checked
// against a reference model that builds the expected bit sequence directly
// from pattern, length and repeat count.
module tb_serial_pattern_tx;

  localparam int MAX_LEN = 8;
  localparam int LEN_W   = 4;
  localparam int REP_W   = 4;

`ifdef SERIAL_PATTERN_TX_GAP_EN
  localparam int GapEn = 1;
`else
  localparam int GapEn = 0;
`endif

  logic               clk = 1'b0;
  logic               rst = 1'b0;
  logic               start_valid = 1'b0;
  logic               start_ready;
  logic [MAX_LEN-1:0] pattern = '0;
  logic [LEN_W-1:0]   len = '0;
  logic [REP_W-1:0]   repeat_cnt = '0;
  logic               out_bit;
  logic               out_valid;
  logic               out_ready = 1'b1;
  logic               busy;
  logic               done;

  serial_pattern_tx #(
    .MAX_LEN(MAX_LEN),
    .LEN_W  (LEN_W),
    .REP_W  (REP_W)
  ) dut (
    .clk        (clk),
    .rst        (rst),
    .start_valid(start_valid),
    .start_ready(start_ready),
    .pattern    (pattern),
    .len        (len),
    .repeat_cnt (repeat_cnt),
    .out_bit    (out_bit),
    .out_valid  (out_valid),
    .out_ready  (out_ready),
    .busy       (busy),
    .done       (done)
  );

  always #5 clk = ~clk;

  int tests = 0;
  int fails = 0;

  bit exp_bits[$];
  bit got_bits[$];
  int done_cyc;
  int last_xfer;
  int gaps;
  int stall_err;
  int timed_out;

  // Reference model: every pass sends bits eff-1 down to 0.
  task automatic build_expected(input logic [7:0] pat, input int ln, input int rp);
    int eff;
    eff = (ln > MAX_LEN) ? MAX_LEN : ln;
    exp_bits.delete();
    for (int p = 0; p <= rp; p++)
      for (int i = eff - 1; i >= 0; i--) exp_bits.push_back(pat[i[2:0]]);
  endtask

  // Issues one start at cycle 0 and records what the DUT emits until done.
  // Cycle k is the k-th falling edge after the start was driven.
  task automatic run_stream(input logic [7:0] pat, input logic [3:0] ln, input logic [3:0] rp,
                            input int ready_pct, input int stall_lo, input int stall_hi,
                            input bit hold_valid);
    bit pv, pr, pb;
    got_bits.delete();
    done_cyc = -1; last_xfer = -1; gaps = 0; stall_err = 0; timed_out = 0;
    pv = 0; pr = 1; pb = 0;
    @(negedge clk);
    start_valid = 1'b1; pattern = pat; len = ln; repeat_cnt = rp; out_ready = 1'b1;
    for (int cyc = 1; cyc <= 3000; cyc++) begin
      @(negedge clk);
      if (!hold_valid) start_valid = 1'b0;
      if (cyc == 1 && !hold_valid) begin
        pattern = 8'($urandom); len = 4'($urandom); repeat_cnt = 4'($urandom);
      end
      if (pv && !pr && (out_valid !== 1'b1 || out_bit !== pb)) stall_err++;
      if (done === 1'b1) begin
        done_cyc = cyc;
        break;
      end
      if (busy === 1'b1 && out_valid !== 1'b1) gaps++;
      if (cyc >= stall_lo && cyc <= stall_hi) out_ready = 1'b0;
      else out_ready = ($urandom_range(99) < ready_pct);
      if (out_valid === 1'b1 && out_ready === 1'b1) begin
        got_bits.push_back(out_bit);
        last_xfer = cyc;
      end
      pv = out_valid; pr = out_ready; pb = out_bit;
      if (cyc == 3000) timed_out = 1;
    end
    out_ready = 1'b1;
  endtask

  task automatic test_reset();
    rst = 1'b0;
    start_valid = 1'b1; pattern = 8'hff; len = 4'd8;
    repeat (3) @(negedge clk);
    tests++; if (out_valid !== 1'b0) begin fails++; $display("FAIL reset_valid got %b exp 0", out_valid); end
    tests++; if (out_bit !== 1'b0) begin fails++; $display("FAIL reset_bit got %b exp 0", out_bit); end
    tests++; if (busy !== 1'b0) begin fails++; $display("FAIL reset_busy got %b exp 0", busy); end
    tests++; if (done !== 1'b0) begin fails++; $display("FAIL reset_done got %b exp 0", done); end
    tests++; if (start_ready !== 1'b1) begin fails++; $display("FAIL reset_ready got %b exp 1", start_ready); end
    start_valid = 1'b0;
    rst = 1'b1;
    @(negedge clk);
  endtask

  task automatic test_basic();
    build_expected(8'b0011_0011, 6, 0);
    run_stream(8'b0011_0011, 4'd6, 4'd0, 100, 0, -1, 1'b0);
    tests++; if (got_bits.size() != 6) begin fails++; $display("FAIL basic_count got %0d exp 6", got_bits.size()); end
    for (int i = 0; i < exp_bits.size() && i < got_bits.size(); i++) begin
      tests++; if (got_bits[i] != exp_bits[i]) begin fails++; $display("FAIL basic_bit%0d got %b exp %b", i, got_bits[i], exp_bits[i]); end
    end
    tests++; if (done_cyc != 7) begin fails++; $display("FAIL basic_done_cycle got %0d exp 7", done_cyc); end
    @(negedge clk);
    tests++; if (done !== 1'b0) begin fails++; $display("FAIL basic_done_width got %b exp 0", done); end
  endtask

  task automatic test_repeats();
    build_expected(8'b0011_0011, 6, 2);
    run_stream(8'b0011_0011, 4'd6, 4'd2, 100, 0, -1, 1'b0);
    tests++; if (got_bits != exp_bits) begin fails++; $display("FAIL repeats_bits got %p exp %p", got_bits, exp_bits); end
    tests++; if (gaps != 2 * GapEn) begin fails++; $display("FAIL repeats_gaps got %0d exp %0d", gaps, 2 * GapEn); end
    tests++; if (done_cyc != 19 + 2 * GapEn) begin fails++; $display("FAIL repeats_done got %0d exp %0d", done_cyc, 19 + 2 * GapEn); end
  endtask

  task automatic test_stall();
    build_expected(8'b0000_1010, 4, 0);
    run_stream(8'b0000_1010, 4'd4, 4'd0, 100, 2, 4, 1'b0);
    tests++; if (got_bits != exp_bits) begin fails++; $display("FAIL stall_bits got %p exp %p", got_bits, exp_bits); end
    tests++; if (stall_err != 0) begin fails++; $display("FAIL stall_hold got %0d changes exp 0", stall_err); end
    tests++; if (done_cyc != 8) begin fails++; $display("FAIL stall_done got %0d exp 8", done_cyc); end
  endtask

  task automatic test_boundary();
    logic [7:0] p;
    run_stream(8'hA5, 4'd0, 4'd3, 100, 0, -1, 1'b0);
    tests++; if (done_cyc != 1) begin fails++; $display("FAIL len0_done got %0d exp 1", done_cyc); end
    tests++; if (got_bits.size() != 0 || gaps != 0) begin fails++; $display("FAIL len0_valid got %0d bits exp 0", got_bits.size()); end

    p = 8'($urandom);
    build_expected(p, 12, 0);
    run_stream(p, 4'd12, 4'd0, 100, 0, -1, 1'b0);
    tests++; if (got_bits != exp_bits) begin fails++; $display("FAIL len12_bits got %p exp %p", got_bits, exp_bits); end
    tests++; if (got_bits.size() == 0 || got_bits[0] != p[7]) begin fails++; $display("FAIL len12_first got size %0d exp first %b", got_bits.size(), p[7]); end
    tests++; if (done_cyc != 9) begin fails++; $display("FAIL len12_done got %0d exp 9", done_cyc); end

    p = 8'($urandom);
    build_expected(p, 2, 15);
    run_stream(p, 4'd2, 4'd15, 100, 0, -1, 1'b0);
    tests++; if (got_bits != exp_bits) begin fails++; $display("FAIL rep_max_bits got %0d bits exp %0d", got_bits.size(), exp_bits.size()); end
    tests++; if (done_cyc != 33 + 15 * GapEn) begin fails++; $display("FAIL rep_max_done got %0d exp %0d", done_cyc, 33 + 15 * GapEn); end
  endtask

  task automatic test_reset_mid();
    int dcount;
    @(negedge clk);
    start_valid = 1'b1; pattern = 8'b0011_0011; len = 4'd6; repeat_cnt = 4'd0; out_ready = 1'b1;
    @(negedge clk);
    start_valid = 1'b0;
    repeat (2) @(negedge clk);
    rst = 1'b0;
    #1;
    tests++; if (out_valid !== 1'b0) begin fails++; $display("FAIL rstmid_valid got %b exp 0", out_valid); end
    tests++; if (busy !== 1'b0) begin fails++; $display("FAIL rstmid_busy got %b exp 0", busy); end
    tests++; if (out_bit !== 1'b0) begin fails++; $display("FAIL rstmid_bit got %b exp 0", out_bit); end
    tests++; if (start_ready !== 1'b1) begin fails++; $display("FAIL rstmid_ready got %b exp 1", start_ready); end
    dcount = 0;
    repeat (2) begin @(negedge clk); if (done === 1'b1) dcount++; end
    rst = 1'b1;
    repeat (3) begin @(negedge clk); if (done === 1'b1 || out_valid === 1'b1) dcount++; end
    tests++; if (dcount != 0) begin fails++; $display("FAIL rstmid_no_done got %0d events exp 0", dcount); end
    build_expected(8'b0011_0011, 6, 0);
    run_stream(8'b0011_0011, 4'd6, 4'd0, 100, 0, -1, 1'b0);
    tests++; if (got_bits != exp_bits || done_cyc != 7) begin fails++; $display("FAIL rstmid_restart got %p done %0d exp %p done 7", got_bits, done_cyc, exp_bits); end
  endtask

  task automatic test_back_to_back();
    int n;
    bit seen;
    build_expected(8'b1011_0110, 5, 1);
    run_stream(8'b1011_0110, 4'd5, 4'd1, 100, 0, -1, 1'b1);
    tests++; if (got_bits != exp_bits) begin fails++; $display("FAIL b2b_first got %p exp %p", got_bits, exp_bits); end
    tests++; if (done_cyc != 11 + GapEn) begin fails++; $display("FAIL b2b_done got %0d exp %0d", done_cyc, 11 + GapEn); end
    tests++; if (start_ready !== 1'b1) begin fails++; $display("FAIL b2b_ready_at_done got %b exp 1", start_ready); end
    @(negedge clk);
    start_valid = 1'b0;
    tests++; if (out_valid !== 1'b1 || out_bit !== 1'b1) begin fails++; $display("FAIL b2b_restart got v=%b b=%b exp v=1 b=1", out_valid, out_bit); end
    tests++; if (busy !== 1'b1 || done !== 1'b0) begin fails++; $display("FAIL b2b_state got busy=%b done=%b exp 1 0", busy, done); end
    n = 0; seen = 0;
    for (int c = 0; c < 200; c++) begin
      if (done === 1'b1) begin seen = 1; break; end
      if (out_valid === 1'b1) n++;
      @(negedge clk);
    end
    tests++; if (!seen || n != 10) begin fails++; $display("FAIL b2b_second got %0d bits done=%b exp 10 bits done=1", n, seen); end
  endtask

  task automatic test_random();
    logic [7:0] p;
    logic [3:0] ln, rp;
    int pct, eff, exp_gaps;
    for (int it = 0; it < 25; it++) begin
      p = 8'($urandom);
      ln = 4'($urandom);
      rp = ($urandom_range(4) == 0) ? 4'($urandom) : 4'($urandom_range(2));
      pct = $urandom_range(100, 30);
      eff = (ln > MAX_LEN) ? MAX_LEN : int'(ln);
      exp_gaps = (eff > 0) ? GapEn * int'(rp) : 0;
      build_expected(p, int'(ln), int'(rp));
      run_stream(p, ln, rp, pct, 0, -1, 1'b0);
      tests++; if (timed_out != 0) begin fails++; $display("FAIL rand%0d_timeout got %0d exp 0", it, timed_out); end
      tests++; if (got_bits != exp_bits) begin fails++; $display("FAIL rand%0d_bits p=%h len=%0d rep=%0d got %0d bits exp %0d", it, p, ln, rp, got_bits.size(), exp_bits.size()); end
      tests++; if (done_cyc != ((eff > 0) ? last_xfer + 1 : 1)) begin fails++; $display("FAIL rand%0d_done got %0d exp %0d", it, done_cyc, (eff > 0) ? last_xfer + 1 : 1); end
      tests++; if (stall_err != 0) begin fails++; $display("FAIL rand%0d_stall got %0d exp 0", it, stall_err); end
      tests++; if (gaps != exp_gaps) begin fails++; $display("FAIL rand%0d_gaps got %0d exp %0d", it, gaps, exp_gaps); end
    end
  endtask

  initial begin
    test_reset();
    test_basic();
    test_repeats();
    test_stall();
    test_boundary();
    test_reset_mid();
    test_back_to_back();
    test_random();
    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end

endmodule

// File: doc/serial_pattern_tx.md
Name: serial_pattern_tx

Overview:
- Transmit side for the serial sequence detectors; parallel-in, serial-out pattern generator.
- Accepts a pattern word, active length and repeat count over a valid/ready start handshake.
- Shifts the pattern out one bit per transfer, MSB of the active field first, so a downstream shift-register detector sees the pattern in order.
- Used as stimulus source and link driver in front of the sequence detectors.

Parameters:
- MAX_LEN, 8, widest pattern in bits; must be at least 2.
- LEN_W, $clog2(MAX_LEN+1), width of the len port.
- REP_W, 4, width of the repeat_cnt port.

Ports:
- clk  input  1  clock; all state updates on its rising edge.
- rst  input  1  reset, asynchronous, active-low: 0 = reset asserted.
- start_valid  input  1  start request.
- start_ready  output  1  high only in IDLE; a start is accepted when start_valid & start_ready.
- pattern  input  MAX_LEN  bits to send; only pattern[len-1:0] is used.
- len  input  LEN_W  number of bits per repetition.
- repeat_cnt  input  REP_W  extra repetitions; total passes = repeat_cnt+1.
- out_bit  output  1  serial data, registered.
- out_valid  output  1  out_bit is meaningful, registered.
- out_ready  input  1  consumer accepts out_bit this cycle.
- busy  output  1  high in SEND or GAP.
- done  output  1  one-cycle pulse after the final bit transfer.

Behaviour:
- Reset (rst=0, asynchronous):
  - state=IDLE; out_bit=0, out_valid=0, busy=0, done=0, start_ready=1.
  - All internal counters and registers clear to 0; inputs are ignored.
- A bit transfer occurs when out_valid & out_ready.
- States: IDLE, SEND, GAP (GAP exists only with the optional feature).
- IDLE:
  - start_ready=1.
  - On accept, latch pattern, eff_len=min(len,MAX_LEN), and rep=repeat_cnt.
  - If eff_len==0: stay in IDLE and pulse done on the next cycle; out_valid never rises.
  - Otherwise go to SEND, with out_bit=pattern[eff_len-1] and out_valid=1 registered on the same edge. The first bit is visible the cycle after accept (latency 1).
- SEND:
  - If out_ready=0, out_bit and out_valid hold unchanged (stall of any length).
  - On a transfer, the bit index decrements.
  - After bit index 0 with rep>0: decrement rep and restart at index eff_len-1 with no bubble.
  - After bit index 0 with rep==0: go to IDLE, out_valid=0, out_bit=0, done=1 for exactly one cycle.
- done and start_ready are both high in the first IDLE cycle after the final transfer. A new start may be accepted in that cycle.
- start_valid outside IDLE is ignored and not queued. pattern/len/repeat_cnt changes after accept have no effect.
- Reset asserted mid-stream aborts immediately. No done pulse; the partial pattern is not resumed.
- Width rules:
  - The bit index counter is LEN_W bits wide and never wraps below 0.
  - The rep counter is REP_W bits wide; repeat_cnt = all-ones gives 2^REP_W passes.

Optional Feature:
- Macro: SERIAL_PATTERN_TX_GAP_EN.
- Defined:
  - Between repetitions, the block enters GAP for exactly one cycle with out_valid=0 and out_bit=0, then returns to SEND at index eff_len-1.
  - GAP is not inserted after the final pass.
  - GAP lasts one cycle regardless of out_ready.
- Undefined:
  - The GAP state and its logic are absent; repetitions are back-to-back.

Test Plan:
1. Basic pattern:
   - Stimulus: pattern=8'b0011_0011, len=6, repeat_cnt=0, out_ready=1, accept at cycle 0.
   - Response: out_bit 1,1,0,0,1,1 at cycles 1-6 with out_valid=1; done=1 at cycle 7 only. A chained 110011 detector fires.
2. Repeats:
   - Stimulus: same pattern, repeat_cnt=2, out_ready=1.
   - Response: 18 consecutive valid bits (110011 x3) with no bubbles; done at cycle 19.
   - With SERIAL_PATTERN_TX_GAP_EN defined: out_valid=0 at cycles 7 and 14; done at cycle 21.
3. Stall:
   - Stimulus: len=4, pattern=4'b1010; out_ready=0 during cycles 2-4.
   - Response: out_bit stays 0 (second bit) through cycles 2-5; sequence completes 1,0,1,0; done at cycle 8.
4. Boundary lengths:
   - len=0: done at cycle 1, out_valid stays 0.
   - len=12 with MAX_LEN=8: exactly 8 bits are sent, pattern[7] first.
5. Reset mid-stream:
   - Stimulus: drop rst at cycle 3 of a 6-bit send.
   - Response: out_valid, out_bit and busy are 0 immediately (asynchronous); no done pulse; start_ready=1; a new start after release behaves as in scenario 1.
6. Back-to-back:
   - Stimulus: start_valid held high continuously.
   - Response: the second accept occurs in the done cycle; the first bit of the second run appears the next cycle.
